// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared core constants for opcodes, instruction fields and hazard FSM states.
package pipe_hazard_ctrl_pkg;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic [6:0] opcode(input logic [31:0] ir);
        return ir[OPC_LSB +: 7];
    endfunction

    function automatic logic [4:0] rd_f(input logic [31:0] ir);
        return ir[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] rs1_f(input logic [31:0] ir);
        return ir[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] rs2_f(input logic [31:0] ir);
        return ir[RS2_LSB +: 5];
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);
    always_ff @(posedge clk)
        count <= rst ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and mispredict flush control for a 5-stage pipeline.
// Outputs are Mealy: priority reset > mem_wait > EX_mispredict > load-use hazard.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_ID_IR,
    input  logic [31:0]      ID_EX_IR,
    input  logic             EX_mispredict,
    input  logic             mem_wait,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);
    logic [1:0] cur;
    logic [1:0] next;
    logic [3:0] ctl;
    logic       hz;

    function automatic logic load_use(input logic [31:0] ex, input logic [31:0] id);
        logic [6:0] op;
        logic       use1;
        logic       use2;
        op   = opcode(id);
        use1 = op == OP_REG || op == OP_LW || op == OP_SW || op == OP_B;
        use2 = op == OP_REG || op == OP_SW || op == OP_B;
        return opcode(ex) == OP_LW && rd_f(ex) != 5'd0 &&
               ((use1 && rd_f(ex) == rs1_f(id)) || (use2 && rd_f(ex) == rs2_f(id)));
    endfunction

    always_comb begin
        cur  = (state == ST_STALL || state == ST_FLUSH) ? state : ST_RUN;
        hz   = cur == ST_RUN && load_use(ID_EX_IR, IF_ID_IR);
        ctl  = rst           ? 4'b0011 :
               mem_wait      ? 4'b0000 :
               EX_mispredict ? 4'b1111 :
               hz            ? 4'b0001 :
               cur == ST_FLUSH ? 4'b1101 : 4'b1100;
        next = mem_wait ? state : EX_mispredict ? ST_FLUSH : hz ? ST_STALL : ST_RUN;
    end

    assign {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble} = ctl;

    always_ff @(posedge clk)
        state <= rst ? ST_RUN : next;

    sat_counter #(.width(CNT_W)) u_lu (
        .clk  (clk),
        .rst  (rst),
        .inc  (!mem_wait && !EX_mispredict && hz),
        .count(lu_cnt)
    );

    sat_counter #(.width(CNT_W)) u_flush (
        .clk  (clk),
        .rst  (rst),
        .inc  (!mem_wait && EX_mispredict),
        .count(flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;

    logic         clk = 0;
    logic         rst;
    logic [31:0]  if_id_ir;
    logic [31:0]  id_ex_ir;
    logic         mispredict;
    logic         mem_wait;
    logic         pc_write;
    logic         if_id_write;
    logic         if_id_flush;
    logic         id_ex_bubble;
    logic [W-1:0] lu_cnt;
    logic [W-1:0] flush_cnt;
    logic [1:0]   state;

    int passed = 0;
    int total = 0;
    int m_state = 0;
    int m_lu = 0;
    int m_fl = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .IF_ID_IR     (if_id_ir),
        .ID_EX_IR     (id_ex_ir),
        .EX_mispredict(mispredict),
        .mem_wait     (mem_wait),
        .PC_write     (pc_write),
        .IF_ID_write  (if_id_write),
        .IF_ID_flush  (if_id_flush),
        .ID_EX_bubble (id_ex_bubble),
        .lu_cnt       (lu_cnt),
        .flush_cnt    (flush_cnt),
        .state        (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
        return (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
    endfunction

    function automatic logic [31:0] lw_i(input int rd, input int rs1);
        return (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
    endfunction

    // Spec-level hazard: a load whose nonzero destination feeds a source the decode-stage instruction reads.
    function automatic bit ref_hazard(input logic [31:0] ex, input logic [31:0] id);
        int eop = ex % 128;
        int iop = id % 128;
        int rd = (ex / 128) % 32;
        int s1 = (id / 32768) % 32;
        int s2 = (id / 1048576) % 32;
        bit r1 = iop == 51 || iop == 3 || iop == 35 || iop == 99;
        bit r2 = iop == 51 || iop == 35 || iop == 99;
        return eop == 3 && rd != 0 && ((r1 && rd == s1) || (r2 && rd == s2));
    endfunction

    task automatic step(input bit r, input bit mw, input bit mp, input logic [31:0] ex, input logic [31:0] id);
        bit [3:0] exp;
        int nxt;
        rst = r; mem_wait = mw; mispredict = mp; id_ex_ir = ex; if_id_ir = id;
        #1;
        nxt = 0;
        if (r) exp = 4'b0011;
        else if (mw) begin exp = 4'b0000; nxt = m_state; end
        else if (mp) begin exp = 4'b1111; nxt = 2; end
        else if (m_state == 0 && ref_hazard(ex, id)) begin exp = 4'b0001; nxt = 1; end
        else if (m_state == 2) exp = 4'b1101;
        else exp = 4'b1100;
        check("ctl", {pc_write, if_id_write, if_id_flush, id_ex_bubble}, exp);
        check("state", state, m_state);
        check("lu_cnt", lu_cnt, m_lu);
        check("flush_cnt", flush_cnt, m_fl);
        if (r) begin m_lu = 0; m_fl = 0; end
        else if (!mw && mp) m_fl = (m_fl < SAT) ? m_fl + 1 : SAT;
        else if (!mw && nxt == 1) m_lu = (m_lu < SAT) ? m_lu + 1 : SAT;
        m_state = nxt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir = $urandom;
        logic [6:0] ops [6] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h37};
        ir[6:0] = ops[$urandom_range(0, 5)];
        ir[11:7] = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        return ir;
    endfunction

    initial begin
        rst = 1; mem_wait = 0; mispredict = 0; id_ex_ir = 0; if_id_ir = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        // load-use on rs2, then the stall cycle advances normally
        step(0, 0, 0, lw_i(5, 1), add_i(6, 5, 2));
        check("stall_state", state, 1);
        step(0, 0, 0, lw_i(5, 1), add_i(6, 5, 2));
        check("lu_one", lu_cnt, 1);
        // x0 destination never stalls; rs1 match does
        step(0, 0, 0, lw_i(0, 1), add_i(6, 0, 2));
        step(0, 0, 0, lw_i(5, 1), lw_i(7, 5));
        step(0, 0, 0, 0, 0);
        // mispredict beats a coincident hazard
        step(0, 0, 1, lw_i(5, 1), add_i(6, 5, 2));
        check("flush_state", state, 2);
        step(0, 0, 0, lw_i(5, 1), add_i(6, 5, 2));
        step(0, 0, 0, 0, 0);
        // mem_wait freezes a stall for three cycles
        step(0, 0, 0, lw_i(3, 1), add_i(4, 1, 3));
        repeat (3) step(0, 1, 0, lw_i(3, 1), add_i(4, 1, 3));
        step(0, 0, 0, lw_i(3, 1), add_i(4, 1, 3));
        check("post_wait_state", state, 0);
        // reset in the middle of a flush
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, lw_i(5, 1), add_i(6, 5, 2));
        step(0, 0, 0, 0, 0);
        check("post_rst_lu", lu_cnt, 0);
        // back-to-back hazards, twenty of them, saturate the counter
        repeat (40) step(0, 0, 0, lw_i(2, 1), add_i(6, 1, 2));
        check("lu_sat", lu_cnt, SAT);
        repeat (20) step(0, 0, 1, 0, 0);
        check("fl_sat", flush_cnt, SAT);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, rand_ir(), rand_ir());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each saturating event counter.
REQ-002 SHALL have port clk  input  1  the single core clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port IF_ID_IR  input  32  instruction held in the IF/ID register (decode stage).
REQ-005 SHALL have port ID_EX_IR  input  32  instruction held in the ID/EX register (execute stage).
REQ-006 SHALL have port EX_mispredict  input  1  branch in EX resolved against its prediction.
REQ-007 SHALL have port mem_wait  input  1  data memory not ready; whole pipeline must freeze.
REQ-008 SHALL have port PC_write  output  1  PC register update enable.
REQ-009 SHALL have port IF_ID_write  output  1  IF/ID register load enable.
REQ-010 SHALL have port IF_ID_flush  output  1  clear IF/ID to a bubble.
REQ-011 SHALL have port ID_EX_bubble  output  1  load a bubble into ID/EX in place of the decoded instruction.
REQ-012 SHALL have port lu_cnt  output  CNT_W  load-use stall cycles since reset.
REQ-013 SHALL have port flush_cnt  output  CNT_W  mispredict flush events since reset.
REQ-014 SHALL have port state  output  2  current FSM state, for debug.

Function
REQ-015 SHALL decode fields opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20]; opcodes REG 0110011, LW 0000011, SW 0100011, B 1100011.
REQ-016 SHALL define hazard = ID_EX opcode LW, ID_EX rd != 0, and rd equal to IF_ID rs1 (IF_ID opcode REG/LW/SW/B) or rs2 (IF_ID opcode REG/SW/B); other opcodes use no source.
REQ-017 SHALL implement states RUN=0, STALL=1, FLUSH=2; encoding 3 unreachable and treated as RUN.
REQ-018 SHALL produce outputs combinationally from state and inputs (Mealy), with priority mem_wait > EX_mispredict > hazard.
REQ-019 mem_wait=1 in any state: PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, state held, counters held.
REQ-020 EX_mispredict=1 (mem_wait=0, any state): PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1; next state FLUSH; flush_cnt +1.
REQ-021 RUN with hazard (higher priorities clear): PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=1; next STALL; lu_cnt +1.
REQ-022 RUN with no event: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0; stay RUN.
REQ-023 STALL: hazard detection suppressed; normal-advance outputs as REQ-022; next RUN; exactly one bubble per load-use pair.
REQ-024 FLUSH: hazard detection suppressed (IF/ID holds a bubble); PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=1; next RUN.
REQ-025 Counters SHALL saturate at all-ones and never wrap.
REQ-026 Back-to-back hazards (new hazard in the RUN cycle after STALL) SHALL each produce one stall cycle.

Reset
REQ-027 While rst=1 at a clock edge: state←RUN, lu_cnt←0, flush_cnt←0.
REQ-028 While rst=1: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, regardless of other inputs.
REQ-029 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the sequence; first cycle after release behaves as RUN.

Structure
REQ-030 Opcode constants (REG, LW, SW, B), field bit positions and FSM state encodings SHALL live in the shared core package, common with the immediate generator and decoder.
REQ-031 One sub-module SHALL be used: sat_counter (parameter width; inputs clk, rst, inc; output count), instantiated twice.
REQ-032 Hazard comparison SHALL be a pure combinational function inside pipe_hazard_ctrl; no additional sub-modules.

Verification
REQ-033 ID_EX=lw x5,0(x1); IF_ID=add x6,x5,x2 -> cycle 0: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, state→1; cycle 1: normal advance, state→0; lu_cnt=1.
REQ-034 ID_EX=lw x0,0(x1); IF_ID=add x6,x0,x2 -> no stall, PC_write=1, lu_cnt=0; likewise IF_ID=lw x7,0(x5) with ID_EX rd=x5 -> stall (rs1 match).
REQ-035 EX_mispredict=1 and hazard present same cycle -> IF_ID_flush=1, ID_EX_bubble=1, PC_write=1, state→2, flush_cnt=1, lu_cnt=0; next cycle ID_EX_bubble=1, IF_ID_flush=0, state→0.
REQ-036 mem_wait=1 for 3 cycles during STALL -> all enables 0, state stays 1 for 3 cycles, then advances to 0 after mem_wait drops; counters unchanged.
REQ-037 rst=1 in FLUSH -> state=0, counters=0, IF_ID_flush=1, PC_write=0 during reset; CNT_W=4 with 20 hazards -> lu_cnt=15 (saturated).
